// File: rtl/shift_frame_arbiter_if.sv
// Signal bundle between shift_frame_arbiter, its serial requesters, the external
// shift register and the downstream frame consumer.
interface shift_frame_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int FRAME_BITS = 8
);
  localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    ser_data;
  logic [NUM_REQ-1:0]    ser_valid;
  logic [NUM_REQ-1:0]    grant;
  logic                  sr_reset;
  logic                  sr_data;
  logic                  sr_shift_enable;
  logic [FRAME_BITS-1:0] sr_stored_data;
  // out_valid/out_ready: a frame transfers on a rising clk edge where both are
  // high; once out_valid rises it stays high, with out_data and out_src held
  // constant, until that edge. out_ready may toggle freely.
  logic [FRAME_BITS-1:0] out_data;
  logic [SW-1:0]         out_src;
  logic                  out_valid;
  logic                  out_ready;
  logic                  timeout_err;

  modport master (
    input  req, ser_data, ser_valid, sr_stored_data, out_ready,
    output grant, sr_reset, sr_data, sr_shift_enable,
           out_data, out_src, out_valid, timeout_err
  );

  modport slave (
    output req, ser_data, ser_valid, sr_stored_data, out_ready,
    input  grant, sr_reset, sr_data, sr_shift_enable,
           out_data, out_src, out_valid, timeout_err
  );
endinterface

// File: rtl/shift_frame_arbiter.sv
// Round-robin arbiter that lends one external serial-in shift register to a
// requester per frame, clears it first, counts the bits and hands off the word.
module shift_frame_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int FRAME_BITS = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  shift_frame_arbiter_if.master bus,
  output logic [1:0]           o_dbg_state
);
  localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [SW-1:0]      r_gidx;
  logic [SW-1:0]      r_last;
  logic [CW-1:0]      r_bit_cnt;
  logic [TW-1:0]      r_idle_cnt;
  logic               r_timeout_err;

  logic [SW-1:0]      w_pick_idx;
  logic               w_pick_found;
  logic               w_bit_valid;
  logic               w_last_bit;
  logic               w_idle_expired;

  // Scan upward from the requester after the last owner, wrapping once, so the
  // previous owner is always considered last.
  always_comb begin
    int          c;
    logic [SW-1:0] cand;
    w_pick_idx   = '0;
    w_pick_found = 1'b0;
    c            = 0;
    cand         = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      c = int'(r_last) + i;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      cand = SW'(c);
      if (!w_pick_found && bus.req[cand]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = cand;
      end
    end
  end

  assign w_bit_valid    = bus.ser_valid[r_gidx];
  assign w_last_bit     = (r_bit_cnt == CW'(FRAME_BITS - 1));
  assign w_idle_expired = (r_idle_cnt == TW'(TIMEOUT - 1));

  // The register clears with the controller and for the one CLEAR cycle.
  assign bus.sr_reset        = reset && (r_state != S_CLEAR);
  assign bus.sr_data         = (r_state == S_SHIFT) ? bus.ser_data[r_gidx] : 1'b0;
  assign bus.sr_shift_enable = reset && (r_state == S_SHIFT) && w_bit_valid;
  assign bus.grant           = r_grant;
  assign bus.out_data        = bus.sr_stored_data;
  assign bus.out_src         = r_gidx;
  assign bus.out_valid       = (r_state == S_DONE);
  assign bus.timeout_err     = r_timeout_err;
  assign o_dbg_state         = r_state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_gidx        <= '0;
      r_last        <= SW'(NUM_REQ - 1);
      r_bit_cnt     <= '0;
      r_idle_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pick_found) begin
            r_grant <= NUM_REQ'(1) << w_pick_idx;
            r_gidx  <= w_pick_idx;
            r_state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_bit_cnt  <= '0;
          r_idle_cnt <= '0;
          r_state    <= S_SHIFT;
        end
        S_SHIFT: begin
          if (w_bit_valid) begin
            r_idle_cnt <= '0;
            if (w_last_bit) begin
              r_bit_cnt <= '0;
              r_state   <= S_DONE;
            end else begin
              r_bit_cnt <= r_bit_cnt + CW'(1);
            end
          end else if (w_idle_expired) begin
            r_timeout_err <= 1'b1;
            r_grant       <= '0;
            r_last        <= r_gidx;
            r_bit_cnt     <= '0;
            r_idle_cnt    <= '0;
            r_state       <= S_IDLE;
          end else begin
            r_idle_cnt <= r_idle_cnt + TW'(1);
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_grant <= '0;
            r_last  <= r_gidx;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_frame_arbiter.sv
// Bench for shift_frame_arbiter: an external shift register model, serial
// senders, a frame-level reference model compared every cycle, and directed scenes.
module tb_shift_frame_arbiter;
  localparam int N  = 2;
  localparam int FB = 8;
  localparam int TO = 16;

  localparam int P_IDLE  = 0;
  localparam int P_CLEAR = 1;
  localparam int P_SHIFT = 2;
  localparam int P_DONE  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  shift_frame_arbiter_if #(.NUM_REQ(N), .FRAME_BITS(FB)) bus ();

  shift_frame_arbiter #(.NUM_REQ(N), .FRAME_BITS(FB), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / external shift register ----------------
  always #5 clk = ~clk;

  logic [FB-1:0] sr_q;
  always @(posedge clk) begin
    if (!bus.sr_reset) sr_q <= '0;
    else if (bus.sr_shift_enable) sr_q <= {sr_q[FB-2:0], bus.sr_data};
  end
  assign bus.sr_stored_data = sr_q;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;
  logic [FB-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #3;
  endtask

  // ---------------- serial senders and out_ready driver ----------------
  int            lim[N];
  int            gap[N];
  bit            rand_gap[N];
  bit            rand_pat[N];
  bit            junk[N];
  logic [FB-1:0] pat[N];
  int            sent[N];
  int            gctr[N];
  int            ready_mode;
  logic [N-1:0]  prev_grant;
  logic [N-1:0]  drv_v;
  logic [N-1:0]  drv_d;

  initial begin : sender
    prev_grant = '0;
    for (int s = 0; s < N; s++) begin sent[s] = 0; gctr[s] = 0; end
    forever begin
      @(negedge clk);
      for (int s = 0; s < N; s++) begin
        if (bus.grant[s] === 1'b1 && prev_grant[s] === 1'b1) begin
          if (sent[s] < lim[s] && gctr[s] == 0) begin
            drv_v[s] = 1'b1;
            drv_d[s] = pat[s][FB-1-sent[s]];
            sent[s]++;
            gctr[s] = rand_gap[s] ? int'($urandom_range(0, 2)) : gap[s];
          end else begin
            if (gctr[s] > 0) gctr[s]--;
            drv_v[s] = (sent[s] >= lim[s]) && junk[s] && ($urandom_range(0, 1) == 1);
            drv_d[s] = 1'($urandom_range(0, 1));
          end
        end else begin
          sent[s] = 0;
          gctr[s] = 0;
          drv_v[s] = 1'($urandom_range(0, 1));
          drv_d[s] = 1'($urandom_range(0, 1));
          if (rand_pat[s]) pat[s] = FB'($urandom_range(0, 255));
        end
      end
      prev_grant    = bus.grant;
      bus.ser_valid = drv_v;
      bus.ser_data  = drv_d;
      bus.out_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  initial begin : model
    int phase, owner, last, idle;
    bit terr, found;
    bit bits_q[$];
    logic [FB-1:0] word;
    logic [N-1:0] exp_grant;
    bit exp_en;
    phase = P_IDLE; owner = 0; last = N - 1; idle = 0; terr = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (!model_on) continue;
      exp_grant = (phase == P_IDLE) ? '0 : (N'(1) << owner);
      check("grant", bus.grant, exp_grant);
      check("sr_reset", bus.sr_reset, (reset && phase != P_CLEAR));
      exp_en = reset && (phase == P_SHIFT) && bus.ser_valid[owner];
      check("sr_shift_enable", bus.sr_shift_enable, exp_en);
      if (exp_en) check("sr_data", bus.sr_data, bus.ser_data[owner]);
      check("out_valid", bus.out_valid, (phase == P_DONE));
      check("timeout_err", bus.timeout_err, terr);
      if (phase == P_DONE) begin
        check("out_data", bus.out_data, (exp_q.size() > 0) ? exp_q[0] : 'x);
        check("out_src", bus.out_src, owner);
      end
      // advance the model by one clock edge
      terr = 1'b0;
      if (!reset) begin
        phase = P_IDLE; last = N - 1; idle = 0;
        bits_q.delete(); exp_q.delete();
      end else begin
        case (phase)
          P_IDLE: if (bus.req != '0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++)
              if (!found && bus.req[(last + k) % N]) begin owner = (last + k) % N; found = 1'b1; end
            phase = P_CLEAR;
          end
          P_CLEAR: begin phase = P_SHIFT; bits_q.delete(); idle = 0; end
          P_SHIFT: if (bus.ser_valid[owner]) begin
            bits_q.push_back(bus.ser_data[owner]);
            idle = 0;
            if (bits_q.size() == FB) begin
              word = '0;
              for (int i = 0; i < FB; i++) word[FB-1-i] = bits_q[i];
              exp_q.push_back(word);
              phase = P_DONE;
            end
          end else begin
            idle++;
            if (idle == TO) begin terr = 1'b1; last = owner; phase = P_IDLE; end
          end
          default: if (bus.out_ready) begin
            void'(exp_q.pop_front());
            last = owner;
            phase = P_IDLE;
          end
        endcase
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic wait_valid(input int budget, input string name, output int k);
    k = 0;
    do begin step(); k++; end while (!bus.out_valid && k < budget);
    check({name, "_valid_seen"}, bus.out_valid, 1'b1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (bus.grant != '0 && k < budget) begin step(); k++; end
    check({name, "_idle"}, bus.grant, '0);
  endtask

  initial begin : stim
    int k, n;
    logic [N-1:0] seq[4];
    logic [N-1:0] pg;
    reset = 1'b0; bus.req = '0; ready_mode = 1;
    for (int s = 0; s < N; s++) begin
      lim[s] = FB; gap[s] = 0; rand_gap[s] = 0; rand_pat[s] = 1; junk[s] = 0; pat[s] = '0;
    end
    repeat (2) step();
    check("rst_grant", bus.grant, '0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_timeout_err", bus.timeout_err, 1'b0);
    check("rst_sr_reset", bus.sr_reset, 1'b0);
    model_on = 1'b1;
    reset = 1'b1;
    step();

    // single frame 1,0,1,1,0,0,1,0 from requester 0
    rand_pat[0] = 0; pat[0] = 8'hB2; bus.req = 2'b01;
    step();
    check("s1_grant", bus.grant, 2'b01);
    check("s1_sr_clear", bus.sr_reset, 1'b0);
    bus.req = '0;
    wait_valid(20, "s1", k);
    check("s1_latency", k, 9);
    check("s1_out_data", bus.out_data, 8'hB2);
    check("s1_out_src", bus.out_src, 0);
    step();
    check("s1_grant_clr", bus.grant, '0);
    check("s1_valid_clr", bus.out_valid, 1'b0);
    rand_pat[0] = 1;

    // round robin with both requesting
    for (int i = 0; i < 4; i++) seq[i] = '0;
    bus.req = 2'b11; k = 0; n = 0; pg = '0;
    while (n < 4 && k < 100) begin
      step(); k++;
      if (bus.grant != '0 && pg == '0) begin seq[n] = bus.grant; n++; end
      pg = bus.grant;
    end
    bus.req = '0;
    check("rr_g0", seq[0], 2'b10);
    check("rr_g1", seq[1], 2'b01);
    check("rr_g2", seq[2], 2'b10);
    check("rr_g3", seq[3], 2'b01);
    wait_idle(40, "rr");

    // gapped bits from requester 1
    gap[1] = 3; rand_pat[1] = 0; pat[1] = 8'h6D; bus.req = 2'b10;
    wait_valid(60, "s3", k);
    bus.req = '0;
    check("s3_latency", k, 31);
    check("s3_out_data", bus.out_data, 8'h6D);
    check("s3_out_src", bus.out_src, 1);
    gap[1] = 0; rand_pat[1] = 1;
    wait_idle(10, "s3");

    // timeout after three bits, then a fresh frame into a cleared register
    rand_pat[0] = 0; pat[0] = 8'hE0; lim[0] = 3; bus.req = 2'b01; k = 0;
    while (bus.timeout_err !== 1'b1 && k < 40) begin step(); k++; end
    check("s4_terr_cycle", k, 21);
    check("s4_grant_clr", bus.grant, '0);
    lim[0] = FB; pat[0] = 8'h5C;
    step();
    check("s4_terr_pulse", bus.timeout_err, 1'b0);
    check("s4_regrant", bus.grant, 2'b01);
    bus.req = '0;
    wait_valid(20, "s4", k);
    check("s4_out_data", bus.out_data, 8'h5C);
    rand_pat[0] = 1;
    wait_idle(10, "s4");

    // backpressure while requester 1 keeps strobing
    rand_pat[1] = 0; pat[1] = 8'hA7; junk[1] = 1; ready_mode = 0; bus.req = 2'b10;
    wait_valid(20, "s5", k);
    bus.req = '0;
    for (int i = 0; i < 10; i++) begin
      check("s5_valid_held", bus.out_valid, 1'b1);
      check("s5_data_stable", bus.out_data, 8'hA7);
      check("s5_no_shift", bus.sr_shift_enable, 1'b0);
      step();
    end
    ready_mode = 1;
    step();
    check("s5_before_accept", bus.out_valid, 1'b1);
    step();
    check("s5_accepted", bus.out_valid, 1'b0);
    check("s5_grant_clr", bus.grant, '0);
    junk[1] = 0; rand_pat[1] = 1;

    // reset mid-frame
    bus.req = 2'b01; k = 0;
    while (sent[0] < 5 && k < 20) begin step(); k++; end
    check("s6_five_bits", sent[0], 5);
    step();
    reset = 1'b0;
    #1;
    check("s6_sr_reset", bus.sr_reset, 1'b0);
    step();
    check("s6_grant", bus.grant, '0);
    check("s6_out_valid", bus.out_valid, 1'b0);
    check("s6_no_terr", bus.timeout_err, 1'b0);
    reset = 1'b1; bus.req = 2'b11;
    step();
    check("s6_prio0", bus.grant, 2'b01);
    bus.req = '0;
    wait_idle(20, "s6");

    // randomized traffic
    ready_mode = 2;
    for (int s = 0; s < N; s++) begin rand_gap[s] = 1; junk[s] = 0; end
    for (int c = 0; c < 600; c++) begin
      step();
      if ($urandom_range(0, 3) == 0) bus.req = N'($urandom_range(0, (1 << N) - 1));
      for (int s = 0; s < N; s++)
        if (bus.grant[s] == 1'b0) lim[s] = ($urandom_range(0, 7) == 0) ? 4 : FB;
      reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
    end

    // drain
    reset = 1'b1; bus.req = '0; ready_mode = 1;
    for (int s = 0; s < N; s++) begin lim[s] = FB; rand_gap[s] = 0; end
    wait_idle(60, "drain");
    step();
    check("drain_out_valid", bus.out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
